alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Execute-stage front end directly upstream of the ALU. It latches one decoded RV32I instruction from decode through a valid/ready handshake, applies MEM/WB bypass to the register operands, and selects the ALU operands. It generates the 4-bit ALU op code and drives the ALU and the downstream EX/MEM consumer.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill the held instruction and any same-cycle input
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  32  instruction PC
in_rs1_data  in  32  register-file read of rs1
in_rs2_data  in  32  register-file read of rs2
in_rs1  in  5  rs1 index
in_rs2  in  5  rs2 index
in_rd  in  5  destination index
in_imm  in  32  sign-extended immediate
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12]
in_funct7  in  7  instr[31:25]
mem_wen, mem_rd, mem_data  in  1/5/32  MEM-stage writeback bypass source
wb_wen, wb_rd, wb_data  in  1/5/32  WB-stage writeback bypass source
out_valid  out  1  ALU inputs valid
out_ready  in  1  downstream consumes
alu_in1  out  32  ALU operand 1
alu_in2  out  32  ALU operand 2
alu_op  out  4  ALU op: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and
out_rd  out  5  destination index
out_rf_wen  out  1  instruction writes rd
out_store_data  out  32  bypassed rs2 for stores
out_illegal  out  1  undecodable instruction

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on the port named reset. All registers clear on reset, so out_valid=0, alu_op=0000, alu_in1=alu_in2=0, out_rd=0, out_rf_wen=0, out_illegal=0.
- Storage is a single-entry pipeline register. in_ready = !flush && (!valid_q || out_ready). This is a combinational path from out_ready and is documented as such.
- Accept when in_valid && in_ready. Fields are captured at the next edge, and out_valid asserts 1 cycle after acceptance. Back-to-back throughput is 1 instruction/cycle.
- On out_valid && !out_ready, every output holds stable.
- flush clears valid_q at the next edge. It dominates a simultaneous accept. Reset dominates flush.
- Bypass is combinational on the latched rs data:
  - Priority: mem, then wb, then latched.
  - A source matches only if wen=1, rd==rs, and rs!=0.
  - Index x0 always reads 0.
- While stalled, a wb match overwrites the latched rs data so the write is not lost.
- Op and operand selection by opcode:
  - 0110011 OP: funct3 000 gives sub if funct7[5] else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 gives sra if funct7[5] else srl; 110 or; 111 and. Operands are rs1, rs2.
  - 0010011 OP-IMM: same mapping, except 000 is always add. Operands are rs1, imm.
  - For shifts, alu_in2 = {27'b0, operand[4:0]}.
  - 0110111 LUI: in1=0, in2=imm, add.
  - 0010111 AUIPC: in1=pc, in2=imm, add.
  - 0000011/0100011 load/store: in1=rs1, in2=imm, add.
  - 1101111/1100111 JAL/JALR: in1=pc, in2=4, add (link value).
  - 1100011 branch: in1=rs1, in2=rs2. funct3 00x gives sub; 10x gives slt; 11x gives sltu; 01x is illegal.
- Illegal cases:
  - Unknown opcode.
  - OP with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
  - OP-IMM shift with funct7 not in {0000000, 0100000 (101 only)}.
  - Illegal instructions force alu_op=add and out_rf_wen=0, and still flow downstream with out_illegal=1.
- out_rf_wen = legal && rd!=0 && opcode in {OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR}.

Optional Feature:
ALU_ISSUE_BYPASS_EN. When defined, MEM/WB bypass and the stall refresh are present. When undefined, the mem_*/wb_* ports exist but are ignored, and raw latched operands are used; hazard interlock is then the responsibility of decode.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum with the 4-bit codes above.
  - RV32I opcode constants.
  - funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- Natural sub-module: alu_op_decode, combinational. It maps (opcode, funct3, funct7) to alu_op, operand selects, rf_wen and illegal.

Test Plan:
- Reset then idle: out_valid=0, alu_op=0000, alu_in1=alu_in2=0.
- OP sub with rs1=5, rs2=7, funct7=0100000 and out_ready=1: next cycle out_valid=1, alu_op=0001, in1=5, in2=7, out_rf_wen=1.
- OP-IMM srai with imm=0x40000023 and rs1=0x80000000: alu_op=0111, alu_in2=0x00000003.
- ALU_ISSUE_BYPASS_EN: rs1=x3, mem_rd=3 (data 0xAA), wb_rd=3 (data 0xBB): alu_in1=0xAA. With rs1=x0 and mem_rd=0 (wen=1): alu_in1=0.
- Stall 3 cycles (out_ready=0) with wb writing rs2 mid-stall: outputs stable, in_ready=0, and out_store_data is the new wb_data after release.
- flush together with in_valid=1 while holding a valid entry: next cycle out_valid=0 and the input is not accepted. Opcode 1111111 gives out_illegal=1 and out_rf_wen=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes, RV32I
// opcodes, funct7 patterns and the decoded-control bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IN1_RS1  = 2'd0,
    IN1_PC   = 2'd1,
    IN1_ZERO = 2'd2
  } in1_sel_t;

  typedef enum logic [1:0] {
    IN2_RS2  = 2'd0,
    IN2_IMM  = 2'd1,
    IN2_FOUR = 2'd2
  } in2_sel_t;

  // shamt: operand 2 is truncated to its low five bits (shift amount).
  typedef struct packed {
    alu_op_t  alu_op;
    in1_sel_t in1_sel;
    in2_sel_t in2_sel;
    logic     shamt;
    logic     rf_wen;
    logic     illegal;
  } dec_t;

  // funct3 -> op for the register/immediate arithmetic group; alt is funct7[5].
  function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: (opcode, funct3, funct7, rd) -> ALU op,
// operand selects, register-write enable and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  output dec_t       dec
);

  logic legal;
  logic writes_rd;
  logic is_shift;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    legal     = 1'b1;
    writes_rd = 1'b0;
    dec       = '{alu_op: ALU_ADD, in1_sel: IN1_RS1, in2_sel: IN2_RS2,
                  shamt: 1'b0, rf_wen: 1'b0, illegal: 1'b0};
    case (opcode)
      OPC_OP: begin
        writes_rd  = 1'b1;
        dec.alu_op = arith_op(funct3, funct7[5]);
        dec.shamt  = is_shift;
        if (funct7 == F7_ALT) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        else                  legal = (funct7 == F7_BASE);
      end
      OPC_OP_IMM: begin
        writes_rd   = 1'b1;
        dec.in2_sel = IN2_IMM;
        dec.alu_op  = (funct3 == 3'b000) ? ALU_ADD : arith_op(funct3, funct7[5]);
        dec.shamt   = is_shift;
        // Only the shift encodings constrain the upper immediate bits.
        if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      OPC_LUI: begin
        writes_rd   = 1'b1;
        dec.in1_sel = IN1_ZERO;
        dec.in2_sel = IN2_IMM;
      end
      OPC_AUIPC: begin
        writes_rd   = 1'b1;
        dec.in1_sel = IN1_PC;
        dec.in2_sel = IN2_IMM;
      end
      OPC_LOAD: begin
        writes_rd   = 1'b1;
        dec.in2_sel = IN2_IMM;
      end
      OPC_STORE: begin
        dec.in2_sel = IN2_IMM;
      end
      OPC_JAL, OPC_JALR: begin
        writes_rd   = 1'b1;
        dec.in1_sel = IN1_PC;
        dec.in2_sel = IN2_FOUR;
      end
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.alu_op = ALU_ADD;
      dec.shamt  = 1'b0;
    end
    dec.rf_wen  = legal && writes_rd && (rd != 5'd0);
    dec.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry execute-stage issue register feeding the ALU, with operand
// bypass from MEM/WB when ALU_ISSUE_BYPASS_EN is defined.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_op,
  output logic [4:0]      out_rd,
  output logic            out_rf_wen,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  dec_t            dec_q,      dec_d;

  dec_t            dec_in;
  logic            accept;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op2_sel;

  alu_op_decode u_decode (
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .dec    (dec_in)
  );

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready. in_ready is combinational from
  // out_ready and flush, so the entry can be replaced in the cycle it drains.
  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2, stall;

  assign mem_hit1 = mem_wen && (mem_rd == rs1_q) && (rs1_q != 5'd0);
  assign mem_hit2 = mem_wen && (mem_rd == rs2_q) && (rs2_q != 5'd0);
  assign wb_hit1  = wb_wen  && (wb_rd  == rs1_q) && (rs1_q != 5'd0);
  assign wb_hit2  = wb_wen  && (wb_rd  == rs2_q) && (rs2_q != 5'd0);
  assign stall    = valid_q && !out_ready;
`else
  logic unused_bypass;
  assign unused_bypass = ^{mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data};
`endif

  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_hit1)  rs1_fwd = wb_data;
    if (mem_hit1) rs1_fwd = mem_data;
    if (wb_hit2)  rs2_fwd = wb_data;
    if (mem_hit2) rs2_fwd = mem_data;
`endif
    if (rs1_q == 5'd0) rs1_fwd = '0;
    if (rs2_q == 5'd0) rs2_fwd = '0;
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    dec_d      = dec_q;
    if (accept) begin
      pc_d       = in_pc;
      imm_d      = in_imm;
      rs1_data_d = in_rs1_data;
      rs2_data_d = in_rs2_data;
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      rd_d       = in_rd;
      dec_d      = dec_in;
    end
`ifdef ALU_ISSUE_BYPASS_EN
    // A WB write seen while stalled is gone next cycle, so fold it into
    // the held operand now.
    else if (stall) begin
      if (wb_hit1) rs1_data_d = wb_data;
      if (wb_hit2) rs2_data_d = wb_data;
    end
`endif
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      dec_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      dec_q      <= dec_d;
    end
  end

  always_comb begin
    case (dec_q.in1_sel)
      IN1_RS1: alu_in1 = rs1_fwd;
      IN1_PC:  alu_in1 = pc_q;
      default: alu_in1 = '0;
    endcase
    case (dec_q.in2_sel)
      IN2_IMM:  op2_sel = imm_q;
      IN2_FOUR: op2_sel = XLEN'(4);
      default:  op2_sel = rs2_fwd;
    endcase
    alu_in2 = dec_q.shamt ? {{(XLEN-5){1'b0}}, op2_sel[4:0]} : op2_sel;
  end

  assign out_valid      = valid_q;
  assign alu_op         = dec_q.alu_op;
  assign out_rd         = rd_q;
  assign out_rf_wen     = dec_q.rf_wen;
  assign out_illegal    = dec_q.illegal;
  assign out_store_data = rs2_fwd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage; bypass scenarios follow ALU_ISSUE_BYPASS_EN.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [6:0]  in_opcode = '0, in_funct7 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_wen = 1'b0, wb_wen = 1'b0;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_data = '0, wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_in1, alu_in2, out_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_rf_wen, out_illegal;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .out_store_data(out_store_data), .out_illegal(out_illegal)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] st;
    logic        ill;
    logic        ops;   // in1/in2 meaningful (legal instruction)
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en = 1'b0;
  bit   stab_en = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   prev_stall = 1'b0;
  logic [107:0] snap;
  exp_t mon_e;

  // Reference decode written per instruction class.
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    logic legal, writes;
    legal = 1'b1; writes = 1'b0;
    e.op = 4'd0; e.in1 = a; e.in2 = b; e.rd = rd; e.st = b;
    e.wen = 1'b0; e.ill = 1'b0; e.ops = 1'b1;
    case (opc)
      7'h33: begin
        writes = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: e.op = 4'd0;
          {7'h20, 3'd0}: e.op = 4'd1;
          {7'h00, 3'd1}: e.op = 4'd2;
          {7'h00, 3'd2}: e.op = 4'd3;
          {7'h00, 3'd3}: e.op = 4'd4;
          {7'h00, 3'd4}: e.op = 4'd5;
          {7'h00, 3'd5}: e.op = 4'd6;
          {7'h20, 3'd5}: e.op = 4'd7;
          {7'h00, 3'd6}: e.op = 4'd8;
          {7'h00, 3'd7}: e.op = 4'd9;
          default:       legal = 1'b0;
        endcase
        if (f3 == 3'd1 || f3 == 3'd5) e.in2 = b & 32'h1f;
      end
      7'h13: begin
        writes = 1'b1;
        e.in2 = imm;
        case (f3)
          3'd0: e.op = 4'd0;
          3'd1: begin e.op = 4'd2; legal = (f7 == 7'h00); e.in2 = imm & 32'h1f; end
          3'd2: e.op = 4'd3;
          3'd3: e.op = 4'd4;
          3'd4: e.op = 4'd5;
          3'd5: begin
            e.in2 = imm & 32'h1f;
            if (f7 == 7'h00)      e.op = 4'd6;
            else if (f7 == 7'h20) e.op = 4'd7;
            else                  legal = 1'b0;
          end
          3'd6: e.op = 4'd8;
          default: e.op = 4'd9;
        endcase
      end
      7'h37: begin writes = 1'b1; e.in1 = 32'd0; e.in2 = imm; end
      7'h17: begin writes = 1'b1; e.in1 = pc; e.in2 = imm; end
      7'h03: begin writes = 1'b1; e.in2 = imm; end
      7'h23: e.in2 = imm;
      7'h6f, 7'h67: begin writes = 1'b1; e.in1 = pc; e.in2 = 32'd4; end
      7'h63: begin
        case (f3)
          3'd0, 3'd1: e.op = 4'd1;
          3'd4, 3'd5: e.op = 4'd3;
          3'd6, 3'd7: e.op = 4'd4;
          default:    legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin e.op = 4'd0; e.ill = 1'b1; e.ops = 1'b0; end
    e.wen = legal && writes && (rd != 5'd0);
    return e;
  endfunction

  // Output monitor: pops on every downstream transfer, checks stability during stalls.
  always @(negedge clk) begin
    if (!reset && sb_en && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: output op=%h in1=%h with empty expected queue", alu_op, alu_in1);
      end else begin
        mon_e = exp_q.pop_front();
        if ((alu_op !== mon_e.op) || (out_rd !== mon_e.rd) || (out_rf_wen !== mon_e.wen) ||
            (out_illegal !== mon_e.ill) || (out_store_data !== mon_e.st) ||
            (mon_e.ops && ((alu_in1 !== mon_e.in1) || (alu_in2 !== mon_e.in2)))) begin
          errors++;
          $display("FAIL sb_out: got op=%h in1=%h in2=%h rd=%0d wen=%b st=%h ill=%b exp op=%h in1=%h in2=%h rd=%0d wen=%b st=%h ill=%b",
                   alu_op, alu_in1, alu_in2, out_rd, out_rf_wen, out_store_data, out_illegal,
                   mon_e.op, mon_e.in1, mon_e.in2, mon_e.rd, mon_e.wen, mon_e.st, mon_e.ill);
        end
      end
    end
    if (stab_en && prev_stall) begin
      checks++;
      if ({out_valid, alu_op, alu_in1, alu_in2, out_rd, out_rf_wen, out_store_data, out_illegal} !== snap) begin
        errors++;
        $display("FAIL stall_stable: got %h required %h", 
                 {out_valid, alu_op, alu_in1, alu_in2, out_rd, out_rf_wen, out_store_data, out_illegal}, snap);
      end
    end
    prev_stall = stab_en && out_valid && !out_ready;
    snap = {out_valid, alu_op, alu_in1, alu_in2, out_rd, out_rf_wen, out_store_data, out_illegal};
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [31:0] pc);
    in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_data = v1; in_rs2_data = v2; in_imm = imm; in_pc = pc;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, return at posedge+1.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm, input logic [31:0] pc);
    int   n;
    exp_t e;
    e = model(opc, f3, f7, rd, (rs1 == 5'd0) ? 32'd0 : v1, (rs2 == 5'd0) ? 32'd0 : v2, imm, pc);
    drive_fields(opc, f3, f7, rs1, rs2, rd, v1, v2, imm, pc);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      if (sb_en) exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    cycles(3);
    @(negedge clk);
    checks++;
    if ({out_valid, alu_op, out_rd, out_rf_wen, out_illegal} !== 12'd0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b op=%h rd=%0d wen=%b ill=%b required all 0",
               out_valid, alu_op, out_rd, out_rf_wen, out_illegal);
    end
    checks++;
    if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_operands: in1=%h in2=%h required 0/0", alu_in1, alu_in2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_op_sub;
    sb_en = 1'b1;
    out_ready = 1'b1;
    send(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h100);
    checks++;
    if (out_valid !== 1'b1 || alu_op !== 4'b0001 || alu_in1 !== 32'd5 ||
        alu_in2 !== 32'd7 || out_rf_wen !== 1'b1) begin
      errors++;
      $display("FAIL op_sub: valid=%b op=%h in1=%h in2=%h wen=%b required 1/1/5/7/1",
               out_valid, alu_op, alu_in1, alu_in2, out_rf_wen);
    end
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL op_sub_drain: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_srai;
    send(7'h13, 3'd5, 7'h20, 5'd5, 5'd0, 5'd6, 32'h80000000, 32'd0, 32'h40000023, 32'h104);
    checks++;
    if (alu_op !== 4'b0111 || alu_in1 !== 32'h80000000 || alu_in2 !== 32'h00000003) begin
      errors++;
      $display("FAIL srai: op=%h in1=%h in2=%h required 7/80000000/00000003", alu_op, alu_in1, alu_in2);
    end
    cycles(1);
  endtask

  task automatic test_illegal;
    send(7'h7f, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 32'h200);
    checks++;
    if (out_illegal !== 1'b1 || out_rf_wen !== 1'b0 || alu_op !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_opcode: ill=%b wen=%b op=%h required 1/0/0", out_illegal, out_rf_wen, alu_op);
    end
    send(7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 32'h204);
    send(7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 32'h208);
    send(7'h63, 3'd2, 7'h00, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h8, 32'h20c);
    send(7'h13, 3'd1, 7'h20, 5'd1, 5'd0, 5'd5, 32'h11, 32'h0, 32'h40000004, 32'h210);
    send(7'h13, 3'd5, 7'h01, 5'd1, 5'd0, 5'd5, 32'h11, 32'h0, 32'h02000004, 32'h214);
    cycles(2);
  endtask

  task automatic test_back_to_back;
    logic [16:0] tbl [22];
    logic [16:0] t;
    logic [4:0]  r1, r2;
    int          n;
    tbl = '{{7'h33,3'd0,7'h00}, {7'h33,3'd0,7'h20}, {7'h33,3'd1,7'h00}, {7'h33,3'd2,7'h00},
            {7'h33,3'd3,7'h00}, {7'h33,3'd4,7'h00}, {7'h33,3'd5,7'h00}, {7'h33,3'd5,7'h20},
            {7'h33,3'd6,7'h00}, {7'h33,3'd7,7'h00}, {7'h13,3'd0,7'h35}, {7'h13,3'd5,7'h20},
            {7'h13,3'd1,7'h00}, {7'h13,3'd7,7'h7f}, {7'h37,3'd3,7'h12}, {7'h17,3'd6,7'h40},
            {7'h03,3'd2,7'h00}, {7'h23,3'd2,7'h00}, {7'h6f,3'd0,7'h00}, {7'h67,3'd0,7'h00},
            {7'h63,3'd0,7'h00}, {7'h63,3'd6,7'h00}};
    rdy_rand = 1'b1;
    stab_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      t  = tbl[$urandom_range(0, 21)];
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      send(t[16:10], t[9:7], t[6:0], r1, r2, 5'($urandom_range(0, 31)),
           $urandom, $urandom, {t[6:0], 25'($urandom)}, $urandom);
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d entries outstanding, required 0", exp_q.size());
    end
    stab_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass;
    sb_en = 1'b0;
    out_ready = 1'b0;
    send(7'h33, 3'd0, 7'h00, 5'd3, 5'd4, 5'd8, 32'h11, 32'h22, 32'h0, 32'h300);
    mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA;
    wb_wen = 1'b1;  wb_rd = 5'd3;  wb_data = 32'hBB;
    @(negedge clk);
    checks++;
    if (alu_in1 !== (BYP ? 32'hAA : 32'h11)) begin
      errors++;
      $display("FAIL byp_mem_prio: in1=%h required %h", alu_in1, BYP ? 32'hAA : 32'h11);
    end
    @(posedge clk); #1;
    mem_wen = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_in1 !== (BYP ? 32'hBB : 32'h11)) begin
      errors++;
      $display("FAIL byp_wb: in1=%h required %h", alu_in1, BYP ? 32'hBB : 32'h11);
    end
    @(posedge clk); #1;
    wb_wen = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_in1 !== (BYP ? 32'hBB : 32'h11) || alu_in2 !== 32'h22) begin
      errors++;
      $display("FAIL byp_refresh: in1=%h in2=%h required %h/00000022", alu_in1, alu_in2,
               BYP ? 32'hBB : 32'h11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h33, 3'd0, 7'h00, 5'd0, 5'd4, 5'd9, 32'h99, 32'h22, 32'h0, 32'h304);
    out_ready = 1'b0;
    mem_wen = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
    wb_wen = 1'b1;  wb_rd = 5'd0;  wb_data = 32'h66;
    @(negedge clk);
    checks++;
    if (alu_in1 !== 32'd0 || alu_in2 !== 32'h22) begin
      errors++;
      $display("FAIL byp_x0: in1=%h in2=%h required 00000000/00000022", alu_in1, alu_in2);
    end
    @(posedge clk); #1;
    mem_wen = 1'b0; wb_wen = 1'b0;
    out_ready = 1'b1;
    cycles(1);
  endtask

  task automatic test_stall_refresh;
    logic [31:0] st_exp;
    st_exp = BYP ? 32'hCAFEF00D : 32'h1234;
    out_ready = 1'b0;
    send(7'h23, 3'd2, 7'h00, 5'd6, 5'd7, 5'd0, 32'h1000, 32'h1234, 32'h8, 32'h400);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D; end
      if (k == 2) wb_wen = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_in1 !== 32'h1000 ||
          alu_in2 !== 32'h8 || alu_op !== 4'd0 || out_rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d in_ready=%b valid=%b in1=%h in2=%h op=%h wen=%b required 0/1/1000/8/0/0",
                 k, in_ready, out_valid, alu_in1, alu_in2, alu_op, out_rf_wen);
      end
      if (k != 1) begin
        checks++;
        if (out_store_data !== ((k == 0) ? 32'h1234 : st_exp)) begin
          errors++;
          $display("FAIL stall_store: cyc=%0d st=%h required %h", k, out_store_data,
                   (k == 0) ? 32'h1234 : st_exp);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_store_data !== st_exp) begin
      errors++;
      $display("FAIL stall_release: valid=%b st=%h required 1/%h", out_valid, out_store_data, st_exp);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    send(7'h33, 3'd4, 7'h00, 5'd1, 5'd2, 5'd10, 32'd3, 32'd5, 32'd0, 32'h500);
    flush = 1'b1;
    in_valid = 1'b1;
    drive_fields(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd11, 32'd9, 32'd0, 32'd1, 32'h504);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_op_sub();
    test_srai();
    test_illegal();
    test_back_to_back();
    test_bypass();
    test_stall_refresh();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
